flag_cond_unit: RTL and testbench
=================================

# flag_cond_unit

Sequential flag and condition unit that sits on the consumer side of the ALU status outputs. It registers the carry, overflow, zero and sign flags produced by each ALU operation and decodes them into a branch-taken decision for the control path. It keeps a small LIFO of saved flags so subroutine calls and returns can preserve the flag context. It also raises an overflow trap request held under a req/ack handshake until the interrupt logic acknowledges it.

## Interface
- STACK_DEPTH, 4: number of saved-flag entries; power of two, at least 2.
- PTR_W, 2: log2(STACK_DEPTH).

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flag_we  in  1  load ALU flags this cycle.
- carry_in, overflow_in, zero_in, sign_in  in  1 each  ALU carry, overflow and zero outputs, plus the ALU result MSB.
- cond  in  3  branch condition code.
- take  out  1  combinational branch decision from the registered flags.
- flags  out  4  registered flags {N,V,C,Z} (bit3..bit0).
- push  in  1  save the current registered flags onto the stack.
- pop  in  1  restore flags from the stack top.
- stack_empty  out  1  no entries held.
- stack_full  out  1  STACK_DEPTH entries held.
- stack_err  out  1  sticky error: illegal push or pop.
- ov_trap_en  in  1  enables the overflow trap.
- trap_req  out  1  overflow trap pending.
- trap_ack  in  1  acknowledges the trap from the interrupt logic.

## Operation
- Flag register:
  - When flag_we=1, it loads {sign_in,overflow_in,carry_in,zero_in} at the edge.
  - Otherwise it holds, unless a pop or swap applies (see stack rules).
- take is a decode of the registered flags only, with no bypass of *_in:
  - 000: 1
  - 001: Z
  - 010: !Z
  - 011: C
  - 100: !C
  - 101: V
  - 110: N
  - 111: N^V (signed less-than)
- Stack: a register array plus a count ptr (0..STACK_DEPTH). stack_empty = (ptr==0); stack_full = (ptr==STACK_DEPTH).
- Stack operations, per cycle:
  - push only, not full: entry[ptr] <= flags (the pre-edge value); ptr+1.
  - pop only, not empty: flags <= entry[ptr-1]; ptr-1.
  - push and pop, not empty (swap): entry[ptr-1] <= flags; flags <= old entry[ptr-1]; ptr unchanged.
  - Illegal cases set stack_err=1 and change neither the stack nor ptr: push when full; pop when empty; push and pop when empty. The flag register still obeys flag_we in an illegal cycle.
- Priority against flag_we: a legal pop or swap overrides flag_we, so restored flags win. push combined with flag_we saves the old flags and then loads the new ones.
- stack_err is sticky and clears only on reset.
- Trap handshake:
  - Event = flag_we & overflow_in & ov_trap_en.
  - An event sets trap_req at the next edge.
  - trap_req stays high until trap_ack=1 is sampled at an edge, which clears it.
  - Event and ack in the same cycle: trap_req remains 1, because the new event is not lost.
  - Events while a trap is pending merge into the pending request, with no counting.
  - trap_ack while trap_req=0 is ignored.
  - Deasserting ov_trap_en does not cancel a pending trap_req.

## Timing
- Reset values: flags=0000, ptr=0, stack_empty=1, stack_full=0, stack_err=0, trap_req=0, all stack entries 0.
- take right after reset: 1 for cond 000, 010, 100; 0 otherwise.
- Flag latency: flags, and therefore take, reflect a flag_we load one cycle after the load cycle.
- Stack latency: pop or swap results are visible on flags the cycle after the pop.
- Trap latency: trap_req rises one cycle after the event cycle and falls one cycle after the ack cycle.
- take is combinational from flags and cond, with no clock latency on cond.
- An asynchronous reset asserted mid-push, mid-pop or with a trap pending returns every output to its reset value immediately. No partial update survives.

## Test plan
- Reset, then flag_we with N,V,C,Z=1,0,1,0 -> next cycle flags=1010; cond 011 gives take=1, cond 111 gives take=1, cond 001 gives take=0.
- Fill the stack: push 4 times with flags 0001,0010,0100,1000 -> stack_full=1. A 5th push -> stack_err=1, ptr stays 4. 4 pops return flags 1000,0100,0010,0001 in order; a 5th pop leaves flags=0001 and stack_empty=1.
- Swap: stack top=0101, flags=0011, push+pop in the same cycle -> flags=0101, top=0011, ptr unchanged.
- pop together with flag_we (inputs give 1111) on a stack with top 0110 -> flags=0110; a later pop on the empty stack sets stack_err.
- Trap: ov_trap_en=1, flag_we with overflow_in=1 -> trap_req=1 the next cycle; it holds 3 idle cycles; trap_ack for 1 cycle -> trap_req=0. Event and ack in the same cycle -> trap_req stays 1.
- Reset asserted asynchronously while ptr=2, trap_req=1 and stack_err=1 -> all outputs return to their reset values before the next clk edge.

Source files
------------

// File: rtl/flag_cond_unit.sv
// ALU flag register with branch-condition decode, a small LIFO of saved flags
// for call/return context, and an overflow trap request held until acknowledged.
module flag_cond_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_we,
    input  logic       carry_in,
    input  logic       overflow_in,
    input  logic       zero_in,
    input  logic       sign_in,
    input  logic [2:0] cond,
    output logic       take,
    output logic [3:0] flags,
    input  logic       push,
    input  logic       pop,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err,
    input  logic       ov_trap_en,
    output logic       trap_req,
    input  logic       trap_ack
);

    localparam logic [PTR_W:0]   FULL_CNT = STACK_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] IDX_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [3:0]       stack_mem [STACK_DEPTH];
    logic [PTR_W:0]   ptr;
    logic [PTR_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             illegal;
    logic             trap_event;

    assign stack_empty = (ptr == '0);
    assign stack_full  = (ptr == FULL_CNT);
    // When full, the low bits wrap to zero and minus one lands on the last entry.
    assign top_idx     = ptr[PTR_W-1:0] - IDX_ONE;

    assign do_push    = push & ~pop & ~stack_full;
    assign do_pop     = pop & ~push & ~stack_empty;
    assign do_swap    = push & pop & ~stack_empty;
    assign illegal    = (push & ~pop & stack_full) | (pop & stack_empty);
    assign trap_event = flag_we & overflow_in & ov_trap_en;

    always_comb begin
        take = 1'b1;
        case (cond)
            3'b000: take = 1'b1;
            3'b001: take = flags[0];
            3'b010: take = ~flags[0];
            3'b011: take = flags[1];
            3'b100: take = ~flags[1];
            3'b101: take = flags[2];
            3'b110: take = flags[3];
            3'b111: take = flags[3] ^ flags[2];
            default: take = 1'b1;
        endcase
    end

    // Trap handshake: trap_req rises the edge after an event and stays high
    // until trap_ack is sampled at an edge with no new event in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags     <= 4'b0000;
            ptr       <= '0;
            stack_err <= 1'b0;
            trap_req  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= 4'b0000;
            end
        end else begin
            // Restored flags take priority over a same-cycle ALU load.
            if (do_pop || do_swap) begin
                flags <= stack_mem[top_idx];
            end else if (flag_we) begin
                flags <= {sign_in, overflow_in, carry_in, zero_in};
            end

            if (do_push) begin
                stack_mem[ptr[PTR_W-1:0]] <= flags;
                ptr                       <= ptr + CNT_ONE;
            end
            if (do_swap) begin
                stack_mem[top_idx] <= flags;
            end
            if (do_pop) begin
                ptr <= ptr - CNT_ONE;
            end
            if (illegal) begin
                stack_err <= 1'b1;
            end

            if (trap_event) begin
                trap_req <= 1'b1;
            end else if (trap_ack) begin
                trap_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed scenarios plus randomized cycles checked
// against a queue-based reference model of flags, saved-flag stack and trap.
module tb_flag_cond_unit;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       flag_we;
    logic       carry_in;
    logic       overflow_in;
    logic       zero_in;
    logic       sign_in;
    logic [2:0] cond;
    logic       take;
    logic [3:0] flags;
    logic       push;
    logic       pop;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;
    logic       ov_trap_en;
    logic       trap_req;
    logic       trap_ack;

    flag_cond_unit #(.STACK_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .flag_we(flag_we),
        .carry_in(carry_in), .overflow_in(overflow_in),
        .zero_in(zero_in), .sign_in(sign_in),
        .cond(cond), .take(take), .flags(flags),
        .push(push), .pop(pop),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err),
        .ov_trap_en(ov_trap_en), .trap_req(trap_req), .trap_ack(trap_ack)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_err;
    logic       m_trap;
    logic [7:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_take(input logic [3:0] f, input logic [2:0] c);
        logic n, v, cy, z;
        {n, v, cy, z} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return v;
            3'd6: return n;
            default: return n != v;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_stack.delete();
        m_err   = 1'b0;
        m_trap  = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic       restored;
        logic [3:0] tmp;
        logic       exp_empty;
        logic       exp_full;
        restored = 1'b0;
        if (flag_we && overflow_in && ov_trap_en) m_trap = 1'b1;
        else if (trap_ack) m_trap = 1'b0;

        if (pop && m_stack.size() > 0) begin
            if (push) begin
                tmp = m_stack[m_stack.size()-1];
                m_stack[m_stack.size()-1] = m_flags;
            end else begin
                tmp = m_stack.pop_back();
            end
            m_flags  = tmp;
            restored = 1'b1;
        end else if (pop) begin
            m_err = 1'b1;
        end else if (push) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_flags);
        end
        if (!restored && flag_we) m_flags = {sign_in, overflow_in, carry_in, zero_in};

        exp_empty = (m_stack.size() == 0);
        exp_full  = (m_stack.size() == DEPTH);
        exp_q.push_back({m_flags, exp_empty, exp_full, m_err, m_trap});
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 8'h1, 8'h0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_flags"}, {4'h0, flags}, {4'h0, e[7:4]});
            check({tag, "_empty"}, {7'h0, stack_empty}, {7'h0, e[3]});
            check({tag, "_full"},  {7'h0, stack_full},  {7'h0, e[2]});
            check({tag, "_err"},   {7'h0, stack_err},   {7'h0, e[1]});
            check({tag, "_trap"},  {7'h0, trap_req},    {7'h0, e[0]});
            check({tag, "_take"},  {7'h0, take},        {7'h0, model_take(e[7:4], cond)});
        end
    endtask

    // driver tasks
    task automatic cycle(input string tag, input logic fw, input logic [3:0] nvcz,
                         input logic ps, input logic pp, input logic ten,
                         input logic ack, input logic [2:0] c);
        @(negedge clk);
        flag_we = fw;
        {sign_in, overflow_in, carry_in, zero_in} = nvcz;
        push = ps; pop = pp; ov_trap_en = ten; trap_ack = ack; cond = c;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic set_inputs_idle();
        flag_we = 0; {sign_in, overflow_in, carry_in, zero_in} = 4'h0;
        push = 0; pop = 0; ov_trap_en = 0; trap_ack = 0; cond = 3'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, {4'h0, flags}, 8'h00);
        check({tag, "_empty"}, {7'h0, stack_empty}, 8'h01);
        check({tag, "_full"},  {7'h0, stack_full}, 8'h00);
        check({tag, "_err"},   {7'h0, stack_err}, 8'h00);
        check({tag, "_trap"},  {7'h0, trap_req}, 8'h00);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        set_inputs_idle();
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_take(input string tag, input logic [2:0] c, input logic exp);
        cond = c;
        #1;
        check(tag, {7'h0, take}, {7'h0, exp});
    endtask

    logic [3:0] fill_vals [4];

    initial begin
        reset = 1'b1;
        set_inputs_idle();
        model_reset();
        fill_vals[0] = 4'b0001; fill_vals[1] = 4'b0010;
        fill_vals[2] = 4'b0100; fill_vals[3] = 4'b1000;
        repeat (2) @(posedge clk);

        // reset state and take decode of all-zero flags
        #1;
        check_reset_values("rst");
        for (int c = 0; c < 8; c++) begin
            cond = c[2:0];
            #0.5;
            check("rst_take", {7'h0, take}, {7'h0, (c == 0 || c == 2 || c == 4) ? 1'b1 : 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;

        // load N,V,C,Z = 1,0,1,0
        cycle("load", 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        check("load_flags", {4'h0, flags}, 8'h0a);
        check_take("take_c3", 3'd3, 1'b1);
        check_take("take_c7", 3'd7, 1'b1);
        check_take("take_c1", 3'd1, 1'b0);

        // fill, overflow, drain, underflow
        do_reset("rst_fill");
        for (int i = 0; i < 4; i++) begin
            cycle("fill_ld", 1'b1, fill_vals[i], 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            cycle("fill_push", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        check("full_flag", {7'h0, stack_full}, 8'h01);
        cycle("push5", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check("push5_err", {7'h0, stack_err}, 8'h01);
        check("push5_full", {7'h0, stack_full}, 8'h01);
        for (int i = 3; i >= 0; i--) begin
            cycle("drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
            check("drain_val", {4'h0, flags}, {4'h0, fill_vals[i]});
        end
        cycle("pop5", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check("pop5_flags", {4'h0, flags}, 8'h01);
        check("pop5_empty", {7'h0, stack_empty}, 8'h01);

        // swap
        do_reset("rst_swap");
        cycle("sw_ld1", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("sw_push", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("sw_ld2", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("swap", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        check("swap_flags", {4'h0, flags}, 8'h05);
        check("swap_noempty", {7'h0, stack_empty}, 8'h00);
        cycle("sw_pop", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check("swap_top", {4'h0, flags}, 8'h03);

        // pop overrides flag_we, then pop on empty
        do_reset("rst_popwe");
        cycle("pw_ld", 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("pw_push", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("pw_pop", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check("popwe_flags", {4'h0, flags}, 8'h06);
        check("popwe_noerr", {7'h0, stack_err}, 8'h00);
        cycle("pw_underflow", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check("underflow_err", {7'h0, stack_err}, 8'h01);

        // trap handshake
        do_reset("rst_trap");
        cycle("tr_ev", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        check("trap_rise", {7'h0, trap_req}, 8'h01);
        repeat (3) idle("tr_hold");
        check("trap_held", {7'h0, trap_req}, 8'h01);
        cycle("tr_ack", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        check("trap_fall", {7'h0, trap_req}, 8'h00);
        cycle("tr_ev2", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        cycle("tr_evack", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        check("trap_evack", {7'h0, trap_req}, 8'h01);
        cycle("tr_ack2", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        cycle("tr_ack_idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        check("trap_stray_ack", {7'h0, trap_req}, 8'h00);
        cycle("tr_en_off", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        check("trap_disabled", {7'h0, trap_req}, 8'h00);

        // asynchronous reset with ptr=2, trap pending, error set
        do_reset("rst_async_pre");
        cycle("as_err", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle("as_ld", 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        cycle("as_push1", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("as_push2", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        check("as_pre_trap", {7'h0, trap_req}, 8'h01);
        check("as_pre_err", {7'h0, stack_err}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b0;
        set_inputs_idle();

        // randomized cycles against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                do_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0),
                      3'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
